// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, instruction
// classes, opcode/funct encodings and the 4-bit ALU operation codes.
package multicycle_ctrl_pkg;

  localparam int MC_MEM_TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_FAULT
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_JUMP
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SLL  = 6'b000000;

  localparam logic [3:0] ALU_OR   = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_DIV  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_SW   = 4'b1100;
  localparam logic [3:0] ALU_LW   = 4'b1101;
  localparam logic [3:0] ALU_BR   = 4'b1110;
  localparam logic [3:0] ALU_JMP  = 4'b1111;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct to ALU code, instruction
// class and a legal flag.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output logic [3:0]   alu_op_o,
  output instr_class_e class_o,
  output logic         legal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_op_o = ALU_OR;
    class_o  = CLS_R;
    legal_o  = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_op_o = ALU_ADD;
          FN_AND:  alu_op_o = ALU_AND;
          FN_DIV:  alu_op_o = ALU_DIV;
          FN_OR:   alu_op_o = ALU_OR;
          FN_XOR:  alu_op_o = ALU_XOR;
          FN_NOR:  alu_op_o = ALU_NOR;
          FN_SUB:  alu_op_o = ALU_SUB;
          FN_SLT:  alu_op_o = ALU_SLT;
          FN_MULT: alu_op_o = ALU_MULT;
          FN_SRA:  alu_op_o = ALU_SRA;
          FN_SRL:  alu_op_o = ALU_SRL;
          FN_SLL:  alu_op_o = ALU_SLL;
          default: legal_o  = 1'b0;
        endcase
      end
      OP_SW: begin
        class_o  = CLS_SW;
        alu_op_o = ALU_SW;
      end
      OP_LW: begin
        class_o  = CLS_LW;
        alu_op_o = ALU_LW;
      end
      OP_BEQ: begin
        class_o  = CLS_BEQ;
        alu_op_o = ALU_BR;
      end
      OP_BNE: begin
        class_o  = CLS_BNE;
        alu_op_o = ALU_BR;
      end
      OP_J: begin
        class_o  = CLS_JUMP;
        alu_op_o = ALU_JMP;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing with
// memory-handshake timeout, sticky error flags and a retired-instruction count.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MC_MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        pc_src,
  output logic        jump_src,
  output logic        illegal,
  output logic        fault,
  output logic [31:0] retired
);

  localparam int WaitW = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [5:0]       funct_q, funct_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic [31:0]      retired_q, retired_d;
  logic             run_q;

  logic [3:0]       dec_alu_op;
  instr_class_e     dec_class;
  logic             dec_legal;
  logic             timeout;
  logic             unused_instr;

  assign unused_instr = ^instr[25:6];

  mc_decode u_decode (
    .opcode_i (opcode_q),
    .funct_i  (funct_q),
    .alu_op_o (dec_alu_op),
    .class_o  (dec_class),
    .legal_o  (dec_legal)
  );

  assign timeout = (wait_q == WaitW'(MEM_TIMEOUT - 1));

  // run_q holds every output low for the first cycle after reset is sampled,
  // so an abandoned access never shows mem_req right after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      opcode_q  <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      run_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    opcode_d   = opcode_q;
    funct_d    = funct_q;
    illegal_d  = illegal_q;
    fault_d    = fault_q;
    retired_d  = retired_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_op     = 4'b0000;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    jump_src   = 1'b0;
    if (run_q) begin
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            opcode_d = instr[31:26];
            funct_d  = instr[5:0];
            state_d  = ST_DECODE;
          end else if (timeout) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        ST_DECODE: begin
          if (dec_legal) begin
            state_d = ST_EXEC;
          end else begin
            illegal_d = 1'b1;
            state_d   = ST_FETCH;
          end
        end
        ST_EXEC: begin
          alu_op = dec_alu_op;
          case (dec_class)
            CLS_R:          state_d = ST_WB;
            CLS_LW, CLS_SW: state_d = ST_MEM;
            CLS_BEQ, CLS_BNE, CLS_JUMP: begin
              // beq redirects on zero=0 and bne on zero=1 in this datapath.
              pc_write  = (dec_class == CLS_JUMP) ||
                          (dec_class == CLS_BEQ && !zero) ||
                          (dec_class == CLS_BNE && zero);
              pc_src    = pc_write && (dec_class != CLS_JUMP);
              jump_src  = (dec_class == CLS_JUMP);
              retired_d = retired_q + 32'd1;
              state_d   = ST_FETCH;
            end
            default: state_d = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          mem_req   = 1'b1;
          iord      = 1'b1;
          reg_dst   = 1'b1;
          alu_op    = dec_alu_op;
          mem_read  = (dec_class == CLS_LW);
          mem_write = (dec_class == CLS_SW);
          if (mem_ready) begin
            if (dec_class == CLS_LW) begin
              state_d = ST_WB;
            end else begin
              retired_d = retired_q + 32'd1;
              state_d   = ST_FETCH;
            end
          end else if (timeout) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (dec_class == CLS_LW);
          reg_dst    = (dec_class == CLS_LW);
          retired_d  = retired_q + 32'd1;
          state_d    = ST_FETCH;
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_FAULT;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each instruction's expected per-cycle
// output trace is queued from a reference model, then popped and compared.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, iord, ir_write, pc_write, reg_write, reg_dst;
  logic        mem_read, mem_write, mem_to_reg, pc_src, jump_src;
  logic [3:0]  alu_op;
  logic        illegal, fault;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .jump_src   (jump_src),
    .illegal    (illegal),
    .fault      (fault),
    .retired    (retired)
  );

  localparam logic [14:0] B_MEM_REQ = 15'd1 << 14;
  localparam logic [14:0] B_IORD    = 15'd1 << 13;
  localparam logic [14:0] B_IR      = 15'd1 << 12;
  localparam logic [14:0] B_PCW     = 15'd1 << 11;
  localparam logic [14:0] B_REGW    = 15'd1 << 10;
  localparam logic [14:0] B_REGDST  = 15'd1 << 9;
  localparam logic [14:0] B_MRD     = 15'd1 << 8;
  localparam logic [14:0] B_MWR     = 15'd1 << 7;
  localparam logic [14:0] B_M2R     = 15'd1 << 6;
  localparam logic [14:0] B_PCSRC   = 15'd1 << 5;
  localparam logic [14:0] B_JSRC    = 15'd1 << 4;

  logic [14:0] obs_vec;
  assign obs_vec = {mem_req, iord, ir_write, pc_write, reg_write, reg_dst, mem_read,
                    mem_write, mem_to_reg, pc_src, jump_src, alu_op};

  typedef struct packed {
    logic        rdy;
    logic [14:0] exp;
  } cyc_t;

  cyc_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_retired = 0;
  logic exp_illegal = 1'b0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference decode straight from the opcode/funct tables: {legal, alu_op}.
  function automatic logic [4:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: return 5'b1_0100;
          6'b100100: return 5'b1_0001;
          6'b011010: return 5'b1_0111;
          6'b100101: return 5'b1_0000;
          6'b100110: return 5'b1_0010;
          6'b100111: return 5'b1_0011;
          6'b100010: return 5'b1_0101;
          6'b101010: return 5'b1_0110;
          6'b011000: return 5'b1_1000;
          6'b000011: return 5'b1_1001;
          6'b000010: return 5'b1_1010;
          6'b000000: return 5'b1_1011;
          default:   return 5'b0_0000;
        endcase
      end
      6'b101011: return 5'b1_1100;
      6'b100011: return 5'b1_1101;
      6'b000100: return 5'b1_1110;
      6'b000101: return 5'b1_1110;
      6'b000010: return 5'b1_1111;
      default:   return 5'b0_0000;
    endcase
  endfunction

  task automatic push(input logic rdy, input logic [14:0] exp);
    cyc_t e;
    e.rdy = rdy;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Queue the expected trace; stray mem_ready=1 outside FETCH/MEM must be ignored.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    logic [4:0]  d;
    logic [3:0]  a;
    logic [14:0] x;
    d = ref_decode(op, fn);
    a = d[3:0];
    for (int i = 0; i < fw; i++) push(1'b0, B_MEM_REQ | B_MRD);
    push(1'b1, B_MEM_REQ | B_MRD | B_IR | B_PCW);
    push(1'b1, '0);
    if (!d[4]) return;
    x = {11'b0, a};
    if (op == 6'b000100 && !z) x |= B_PCW | B_PCSRC;
    if (op == 6'b000101 && z)  x |= B_PCW | B_PCSRC;
    if (op == 6'b000010)       x |= B_PCW | B_JSRC;
    push(1'b1, x);
    if (op == 6'b100011 || op == 6'b101011) begin
      x = B_MEM_REQ | B_IORD | B_REGDST | {11'b0, a} | ((op == 6'b100011) ? B_MRD : B_MWR);
      for (int i = 0; i < mw; i++) push(1'b0, x);
      push(1'b1, x);
    end
    if (op == 6'b000000) push(1'b1, B_REGW);
    if (op == 6'b100011) push(1'b1, B_REGW | B_M2R | B_REGDST);
  endtask

  // Pop and compare one entry per cycle; optionally assert reset in the last one.
  task automatic run(input string name, input int max_cyc, input bit rst_last);
    cyc_t e;
    int   n;
    n = 0;
    while (sb_q.size() > 0 && n < max_cyc) begin
      e = sb_q.pop_front();
      mem_ready = e.rdy;
      if (rst_last && n == max_cyc - 1) rst_n = 1'b0;
      @(negedge clk);
      check($sformatf("%s c%0d", name, n + 1), 32'(obs_vec), 32'(e.exp));
      @(posedge clk);
      #1;
      n++;
    end
    sb_q.delete();
  endtask

  task automatic go(input string name, input logic [5:0] op, input logic [5:0] fn,
                    input logic z, input int fw, input int mw);
    logic [4:0] d;
    d = ref_decode(op, fn);
    instr = {op, 20'hA5C3E, fn};
    zero  = z;
    build(op, fn, z, fw, mw);
    run(name, 1000, 1'b0);
    if (d[4]) exp_retired++;
    else exp_illegal = 1'b1;
  endtask

  // Called just after a reset-sampling edge: the following cycle must be idle.
  task automatic reset_tail(input string name);
    mem_ready = 1'b1;
    @(negedge clk);
    check({name, " outs"},    32'(obs_vec), 32'd0);
    check({name, " retired"}, retired, 32'd0);
    check({name, " illegal"}, 32'(illegal), 32'd0);
    check({name, " fault"},   32'(fault), 32'd0);
    rst_n = 1'b1;
    exp_retired = 0;
    exp_illegal = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_tail("reset");

    go("add",  6'b000000, 6'b100000, 1'b0, 0, 0);
    check("retired after add", retired, 32'(exp_retired));
    go("lw3",  6'b100011, 6'b000000, 1'b0, 0, 3);
    go("sw",   6'b101011, 6'b010101, 1'b1, 2, 0);
    go("beq z0", 6'b000100, 6'b000000, 1'b0, 0, 0);
    go("beq z1", 6'b000100, 6'b000000, 1'b1, 1, 0);
    go("bne z1", 6'b000101, 6'b000000, 1'b1, 0, 0);
    go("bne z0", 6'b000101, 6'b000000, 1'b0, 0, 0);
    go("jump", 6'b000010, 6'b111111, 1'b0, 0, 0);
    go("sub",  6'b000000, 6'b100010, 1'b0, 0, 0);
    go("slt",  6'b000000, 6'b101010, 1'b1, 0, 0);
    go("sll",  6'b000000, 6'b000000, 1'b0, 0, 0);
    go("nor",  6'b000000, 6'b100111, 1'b0, 0, 0);
    go("mult", 6'b000000, 6'b011000, 1'b0, 0, 0);
    go("lw15", 6'b100011, 6'b000000, 1'b0, 15, 15);
    check("retired mix", retired, 32'(exp_retired));
    check("illegal clear", 32'(illegal), 32'(exp_illegal));
    check("fault clear", 32'(fault), 32'd0);

    go("op3f", 6'b111111, 6'b100000, 1'b0, 0, 0);
    check("illegal op", 32'(illegal), 32'(exp_illegal));
    check("retired op3f", retired, 32'(exp_retired));
    go("badfn", 6'b000000, 6'b000001, 1'b0, 0, 0);
    go("or",   6'b000000, 6'b100101, 1'b0, 0, 0);
    check("retired after illegal", retired, 32'(exp_retired));
    check("illegal sticky", 32'(illegal), 32'(exp_illegal));

    instr = {6'b101011, 20'h0, 6'b000000};
    build(6'b101011, 6'b000000, 1'b0, 0, 5);
    run("sw rst", 5, 1'b1);
    reset_tail("sw rst");
    go("add2", 6'b000000, 6'b100000, 1'b0, 0, 0);
    check("retired restart", retired, 32'(exp_retired));

    instr = {6'b000000, 20'h0, 6'b100000};
    for (int i = 0; i < 16; i++) push(1'b0, B_MEM_REQ | B_MRD);
    for (int i = 0; i < 4; i++) push(1'b1, '0);
    run("timeout", 1000, 1'b0);
    check("fault set", 32'(fault), 32'd1);
    check("retired at fault", retired, 32'(exp_retired));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, max cycles waited for mem_ready per access before fault.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  synchronous active-low reset.
REQ-005 Port: instr  in  32  memory read data; opcode [31:26], funct [5:0].
REQ-006 Port: zero  in  1  ALU zero flag from datapath.
REQ-007 Port: mem_ready  in  1  memory access complete this cycle.
REQ-008 Port: mem_req  out  1  memory access request, held until mem_ready.
REQ-009 Port: iord  out  1  address select: 0 = PC (fetch), 1 = ALU result (data).
REQ-010 Port: ir_write, pc_write  out  1 each  IR load strobe; PC update strobe.
REQ-011 Port: alu_op  out  4  ALU operation code.
REQ-012 Port: reg_write, reg_dst, mem_read, mem_write, mem_to_reg, pc_src, jump_src  out  1 each  datapath controls.
REQ-013 Port: illegal, fault  out  1 each  sticky illegal-opcode flag; sticky memory-timeout flag.
REQ-014 Port: retired  out  32  count of completed instructions.

Function
REQ-015 States: FETCH, DECODE, EXEC, MEM, WB, FAULT.
REQ-016 FETCH: mem_req=1, iord=0, mem_read=1; when mem_ready=1, pulse ir_write and pc_write (PC+4), latch opcode/funct internally, go to DECODE.
REQ-017 DECODE: one cycle, no strobes; legal opcode -> EXEC; illegal opcode/funct -> set illegal, increment nothing, return to FETCH.
REQ-018 R-type (opcode 0) ALU codes by funct: 100000->0100, 100100->0001, 011010->0111, 100101->0000, 100110->0010, 100111->0011, 100010->0101, 101010->0110, 011000->1000, 000011->1001, 000010->1010, 000000->1011; any other funct is illegal.
REQ-019 I/J codes: 101011 sw->1100, 100011 lw->1101, 000100 and 000101 branch->1110, 000010 jump->1111.
REQ-020 EXEC: drive alu_op; R-type -> WB; lw/sw -> MEM; branch/jump complete here.
REQ-021 Branch 000100 pulses pc_write with pc_src=1 iff zero=0; branch 000101 iff zero=1; otherwise no pc_write.
REQ-022 Jump pulses pc_write with jump_src=1, pc_src=0.
REQ-023 MEM: mem_req=1, iord=1, reg_dst=1; lw mem_read=1, sw mem_write=1; on mem_ready, lw -> WB, sw completes.
REQ-024 WB: one-cycle reg_write pulse; lw mem_to_reg=1, reg_dst=1; R-type mem_to_reg=0, reg_dst=0.
REQ-025 Latency excluding wait states: R-type 4, lw 5, sw 4, branch/jump 3 cycles; each wait-state cycle adds one.
REQ-026 Outputs not named for a state are 0; alu_op is 0000 outside EXEC and MEM.
REQ-027 retired increments by 1 in the completing cycle of each legal instruction; wraps 0xFFFFFFFF->0.
REQ-028 Wait counter clears on every state entry; if mem_ready is still 0 after MEM_TIMEOUT cycles in FETCH or MEM, set fault and enter FAULT.
REQ-029 FAULT: all strobes 0, mem_req=0; leaves only on reset.
REQ-030 mem_ready outside FETCH/MEM is ignored.
REQ-031 mem_ready on the first request cycle completes the access in that cycle.

Reset
REQ-032 rst_n=0 at a clock edge: state=FETCH, all outputs 0, retired=0, illegal=0, fault=0, wait counter=0.
REQ-033 Reset mid-access abandons the access; mem_req is 0 in the cycle after reset is sampled.

Structure
REQ-034 Shared package holds state enum, opcode/funct constants, 4-bit ALU op constants, and MEM_TIMEOUT default.
REQ-035 One sub-module, mc_decode: combinational opcode/funct -> alu_op, instruction class, legal flag.

Verification
REQ-036 add (funct 100000), mem_ready on first cycle -> ir_write cycle 1, alu_op=0100 cycle 3, reg_write cycle 4, retired=1.
REQ-037 lw with 3 wait states on data access -> reg_write and mem_to_reg=1 in cycle 8, retired=1.
REQ-038 Opcode 000100 with zero=0 -> pc_write, pc_src=1 in EXEC; same opcode with zero=1 -> no pc_write.
REQ-039 Opcode 111111 -> illegal=1, retired unchanged, back in FETCH at cycle 3.
REQ-040 mem_ready held 0 for 16 cycles in FETCH -> fault=1, mem_req=0 thereafter.
REQ-041 rst_n low during a sw wait state -> next cycle all outputs 0, retired=0, FETCH restarts.
